// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore FSM sequencing the multi-cycle MIPS datapath
// Optional feature: define MULTICYCLE_ADDI_EN to add addi (opcode 001000) via ADDIEX/ADDIWB.
module multicycle_control #(
  parameter int MEM_LATENCY = 0
) (
  input  logic       clock_in,
  input  logic       reset_in,
  input  logic [5:0] opcode_in,
  input  logic       zero_in,
  output logic       pcWrite_out,
  output logic [1:0] pcSrc_out,
  output logic       iorD_out,
  output logic       memRead_out,
  output logic       memWrite_out,
  output logic       irWrite_out,
  output logic       memtoReg_out,
  output logic       regWrite_out,
  output logic       regDst_out,
  output logic       aluSrcA_out,
  output logic [1:0] aluSrcB_out,
  output logic [1:0] aluOp_out,
  output logic       illegal_out,
  output logic [3:0] state_out
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif
  localparam logic [3:0] LAT      = 4'(MEM_LATENCY);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_wait;
  logic [5:0] r_opcode;
  logic       w_mem_state;
  logic       w_mem_done;

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_mem_done  = (r_wait == LAT);

  // Wait counter only advances while a memory state is being held; any exit clears it.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_state  <= S_FETCH;
      r_wait   <= '0;
      r_opcode <= '0;
    end else begin
      r_state <= w_next;
      if (w_mem_state && !w_mem_done) r_wait <= r_wait + 4'd1;
      else                            r_wait <= '0;
      if (r_state == S_DECODE) r_opcode <= opcode_in;
    end
  end

  always_comb begin
    w_next       = r_state;
    pcWrite_out  = 1'b0;
    pcSrc_out    = 2'b00;
    iorD_out     = 1'b0;
    memRead_out  = 1'b0;
    memWrite_out = 1'b0;
    irWrite_out  = 1'b0;
    memtoReg_out = 1'b0;
    regWrite_out = 1'b0;
    regDst_out   = 1'b0;
    aluSrcA_out  = 1'b0;
    aluSrcB_out  = 2'b00;
    aluOp_out    = 2'b00;
    illegal_out  = 1'b0;
    state_out    = r_state;
    case (r_state)
      S_FETCH: begin
        memRead_out = 1'b1;
        aluSrcB_out = 2'b01;
        irWrite_out = w_mem_done;
        pcWrite_out = w_mem_done;
        if (w_mem_done) w_next = S_DECODE;
      end
      S_DECODE: begin
        aluSrcB_out = 2'b11;
        case (opcode_in)
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
`ifdef MULTICYCLE_ADDI_EN
          OP_ADDI:      w_next = S_ADDIEX;
`endif
          default: begin
            w_next      = S_FETCH;
            illegal_out = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        aluSrcA_out = 1'b1;
        aluSrcB_out = 2'b10;
        w_next      = (r_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        memRead_out = 1'b1;
        iorD_out    = 1'b1;
        if (w_mem_done) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        regWrite_out = 1'b1;
        memtoReg_out = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWR: begin
        memWrite_out = 1'b1;
        iorD_out     = 1'b1;
        if (w_mem_done) w_next = S_FETCH;
      end
      S_EXECUTE: begin
        aluSrcA_out = 1'b1;
        aluOp_out   = 2'b10;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        regWrite_out = 1'b1;
        regDst_out   = 1'b1;
        w_next       = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcA_out = 1'b1;
        aluOp_out   = 2'b01;
        pcSrc_out   = 2'b01;
        pcWrite_out = zero_in;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        pcWrite_out = 1'b1;
        pcSrc_out   = 2'b10;
        w_next      = S_FETCH;
      end
`ifdef MULTICYCLE_ADDI_EN
      S_ADDIEX: begin
        aluSrcA_out = 1'b1;
        aluSrcB_out = 2'b10;
        w_next      = S_ADDIWB;
      end
      S_ADDIWB: begin
        regWrite_out = 1'b1;
        w_next       = S_FETCH;
      end
`endif
      default: w_next = S_FETCH;
    endcase
    // Reset silences every strobe immediately, so an aborted instruction cannot write.
    if (reset_in) begin
      pcWrite_out  = 1'b0;
      pcSrc_out    = 2'b00;
      iorD_out     = 1'b0;
      memRead_out  = 1'b0;
      memWrite_out = 1'b0;
      irWrite_out  = 1'b0;
      memtoReg_out = 1'b0;
      regWrite_out = 1'b0;
      regDst_out   = 1'b0;
      aluSrcA_out  = 1'b0;
      aluSrcB_out  = 2'b00;
      aluOp_out    = 2'b00;
      illegal_out  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized check of multicycle_control at three memory latencies
// Honours MULTICYCLE_ADDI_EN the same way as the design.
module tb_multicycle_control;

  localparam int NI = 3;
  localparam logic [11:0] LATS = {4'd3, 4'd2, 4'd0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [NI];
  logic [5:0]  opc   [NI];
  logic        zr    [NI];
  logic        pcw   [NI];
  logic [1:0]  pcsrc [NI];
  logic        iord  [NI];
  logic        mrd   [NI];
  logic        mwr   [NI];
  logic        irw   [NI];
  logic        m2r   [NI];
  logic        rgw   [NI];
  logic        rdst  [NI];
  logic        asa   [NI];
  logic [1:0]  asb   [NI];
  logic [1:0]  aop   [NI];
  logic        ill   [NI];
  logic [3:0]  st    [NI];
  logic [15:0] obs   [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    multicycle_control #(.MEM_LATENCY(int'(LATS[g*4 +: 4]))) dut (
      .clock_in(clk), .reset_in(rst[g]), .opcode_in(opc[g]), .zero_in(zr[g]),
      .pcWrite_out(pcw[g]), .pcSrc_out(pcsrc[g]), .iorD_out(iord[g]),
      .memRead_out(mrd[g]), .memWrite_out(mwr[g]), .irWrite_out(irw[g]),
      .memtoReg_out(m2r[g]), .regWrite_out(rgw[g]), .regDst_out(rdst[g]),
      .aluSrcA_out(asa[g]), .aluSrcB_out(asb[g]), .aluOp_out(aop[g]),
      .illegal_out(ill[g]), .state_out(st[g])
    );
    assign obs[g] = {pcw[g], pcsrc[g], iord[g], mrd[g], mwr[g], irw[g], m2r[g],
                     rgw[g], rdst[g], asa[g], asb[g], aop[g], ill[g]};
  end

  typedef enum int {P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
                    P_EXEC, P_ALUWB, P_BRANCH, P_JUMP, P_ADDIEX, P_ADDIWB} ph_t;
  typedef struct { ph_t p; bit last; bit ill; } step_t;

  step_t      seq[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] prev_st;
  ph_t        prev_ph;
  bit         have_prev = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int lat(input int k);
    return int'(LATS[k*4 +: 4]);
  endfunction

  task automatic push(input ph_t p, input int n, input bit il);
    step_t s;
    for (int i = 0; i < n; i++) begin
      s.p = p; s.last = (i == n - 1); s.ill = il;
      seq.push_back(s);
    end
  endtask

  // Instruction -> ordered list of phases, memory phases repeated L+1 times.
  task automatic build(input logic [5:0] op, input int L);
    seq.delete();
    push(P_FETCH, L + 1, 0);
    case (op)
      6'b000000: begin push(P_DECODE, 1, 0); push(P_EXEC, 1, 0); push(P_ALUWB, 1, 0); end
      6'b100011: begin push(P_DECODE, 1, 0); push(P_MEMADR, 1, 0); push(P_MEMRD, L + 1, 0); push(P_MEMWB, 1, 0); end
      6'b101011: begin push(P_DECODE, 1, 0); push(P_MEMADR, 1, 0); push(P_MEMWR, L + 1, 0); end
      6'b000100: begin push(P_DECODE, 1, 0); push(P_BRANCH, 1, 0); end
      6'b000010: begin push(P_DECODE, 1, 0); push(P_JUMP, 1, 0); end
`ifdef MULTICYCLE_ADDI_EN
      6'b001000: begin push(P_DECODE, 1, 0); push(P_ADDIEX, 1, 0); push(P_ADDIWB, 1, 0); end
`endif
      default:   push(P_DECODE, 1, 1);
    endcase
  endtask

  function automatic logic [15:0] expect_out(input step_t s, input logic z);
    logic pw = 0, io = 0, mr = 0, mw = 0, iw = 0, mt = 0, rw = 0, rd = 0, sa = 0, il = 0;
    logic [1:0] ps = 0, sb = 0, ao = 0;
    case (s.p)
      P_FETCH:  begin mr = 1; iw = s.last; pw = s.last; sb = 2'b01; end
      P_DECODE: begin sb = 2'b11; il = s.ill; end
      P_MEMADR: begin sa = 1; sb = 2'b10; end
      P_MEMRD:  begin mr = 1; io = 1; end
      P_MEMWB:  begin rw = 1; mt = 1; end
      P_MEMWR:  begin mw = 1; io = 1; end
      P_EXEC:   begin sa = 1; ao = 2'b10; end
      P_ALUWB:  begin rw = 1; rd = 1; end
      P_BRANCH: begin sa = 1; ao = 2'b01; ps = 2'b01; pw = z; end
      P_JUMP:   begin pw = 1; ps = 2'b10; end
      P_ADDIEX: begin sa = 1; sb = 2'b10; end
      P_ADDIWB: begin rw = 1; end
      default:  ;
    endcase
    return {pw, ps, io, mr, mw, iw, mt, rw, rd, sa, sb, ao, il};
  endfunction

  // Called at posedge+1; leaves at posedge+1 with reset released.
  task automatic do_reset(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      rst[k] = 1'b1;
      opc[k] = 6'($urandom);
      zr[k]  = 1'($urandom);
      #1;
      check($sformatf("L%0d reset c%0d outputs", lat(k), i), obs[k], 32'h0);
      @(posedge clk); #1;
    end
    rst[k] = 1'b0;
    have_prev = 0;
  endtask

  task automatic run_instr(input int k, input logic [5:0] op, input int abort_at, input int zm);
    int  L;
    ph_t p;
    L = lat(k);
    build(op, L);
    for (int i = 0; i < seq.size(); i++) begin
      if (i == abort_at) begin
        do_reset(k, 1);
        return;
      end
      p = seq[i].p;
      opc[k] = (p == P_DECODE) ? op : 6'($urandom);
      zr[k]  = (zm < 0) ? 1'($urandom) : 1'(zm);
      #1;
      check($sformatf("L%0d op%b %s c%0d outputs", L, op, p.name(), i), obs[k], expect_out(seq[i], zr[k]));
      if (have_prev) begin
        if (p == prev_ph) check($sformatf("L%0d %s c%0d state hold", L, p.name(), i), st[k], prev_st);
        else check($sformatf("L%0d %s c%0d state change", L, p.name(), i), st[k] != prev_st, 1);
      end
      prev_st = st[k]; prev_ph = p; have_prev = 1;
      @(posedge clk); #1;
    end
  endtask

  logic [5:0] pick [8];

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; opc[k] = '0; zr[k] = 1'b0;
    end
    pick[0] = 6'b000000; pick[1] = 6'b100011; pick[2] = 6'b101011; pick[3] = 6'b000100;
    pick[4] = 6'b000010; pick[5] = 6'b001000; pick[6] = 6'b111111; pick[7] = 6'b000000;
    @(posedge clk); #1;
    for (int k = 0; k < NI; k++) begin
      do_reset(k, 2);
      run_instr(k, 6'b000000, -1, -1);
      run_instr(k, 6'b100011, -1, -1);
      run_instr(k, 6'b101011, -1, -1);
      run_instr(k, 6'b000100, -1, 1);
      run_instr(k, 6'b000100, -1, 0);
      run_instr(k, 6'b000010, -1, -1);
      run_instr(k, 6'b111111, -1, -1);
      run_instr(k, 6'b001000, -1, -1);
      if (k == 2) begin
        run_instr(k, 6'b101011, 7, -1);
        run_instr(k, 6'b000000, -1, -1);
      end
      for (int n = 0; n < 30; n++) begin
        if ($urandom_range(0, 7) == 0) run_instr(k, 6'($urandom), -1, -1);
        else run_instr(k, pick[$urandom_range(0, 7)], -1, -1);
      end
      if (k == 1) begin
        run_instr(k, 6'b100011, 4, -1);
        run_instr(k, 6'b000010, -1, -1);
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
